// File: rtl/multicycle_main_fsm.sv
// Purpose     : main control FSM of the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Latency     : Moore outputs follow state_q; PCWrite also uses zero, ImmSrc also uses op.
// Backpressure: none. FETCH is held for FETCH_WAIT extra cycles for slow instruction memory.
//
// Ports:
//   clk, reset            core clock; synchronous active-high reset
//   op[6:0], zero         IR opcode field; ALU zero flag (used in BEQ)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc     datapath mux and decoder selects
//   state[3:0]            current state encoding, for debug
//
// Optional build macro MULTICYCLE_ILLEGAL_TRAP_EN:
//   defined   -> an unsupported opcode traps in the absorbing ILLEGAL state (11);
//                only reset leaves it.
//   undefined -> an unsupported opcode returns to FETCH and executes as a NOP.
module multicycle_main_fsm #(
   parameter int unsigned FETCH_WAIT = 0   // 0..15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       RegWrite,
   output logic [1:0] ImmSrc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [3:0] WAIT_LAST = 4'(FETCH_WAIT);

   state_t     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       fetch_done;
   logic       pc_update;
   logic       branch;

   // Last FETCH cycle: instruction memory data is valid, so IR and PC may load.
   assign fetch_done = (wait_cnt_q == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         S_FETCH: begin
            if (fetch_done) begin
               state_d    = S_DECODE;
               wait_cnt_d = 4'd0;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
               default:      state_d = S_ILLEGAL;
`else
               // PC already advanced by 4 in FETCH, so this behaves as a NOP.
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR,
         S_EXECI,
         S_JAL:      state_d = S_ALUWB;
         S_MEMWB,
         S_MEMWRITE,
         S_ALUWB,
         S_BEQ:      state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
         S_ILLEGAL:  state_d = S_ILLEGAL;
`else
         S_ILLEGAL:  state_d = S_FETCH;   // unreachable in this build
`endif
         default:    state_d = S_FETCH;   // unused encodings 12..15
      endcase
   end

   // Moore outputs; anything not set for a state stays 0.
   always_comb begin
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      RegWrite  = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC + 4 computed every FETCH cycle, committed only in the last one.
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = fetch_done;
            pc_update = fetch_done;
         end
         S_DECODE: begin
            // OldPC + imm: branch/jump target precomputed into ALUOut.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
         end
         S_JAL: begin
            // PC <- target held in ALUOut; ALU forms OldPC + 4 for the link write.
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   assign PCWrite = pc_update | (branch & zero);

   always_comb begin
      case (op)
         OP_LW, OP_I: ImmSrc = 2'b00;
         OP_SW:       ImmSrc = 2'b01;
         OP_BEQ:      ImmSrc = 2'b10;
         OP_JAL:      ImmSrc = 2'b11;
         default:     ImmSrc = 2'b00;
      endcase
   end

   assign state = state_q;

endmodule
